// File: rtl/fusion_sched.sv
// fusion_sched: feeds one IMU sample set through the X/Y/Z filters on a shared bus,
// collects their results behind a valid/ready port, and owns filter reset and stall recovery.
module fusion_sched #(
    parameter int FILT_LAT = 5,
    parameter int TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic [15:0] acl_x,
    input  logic [15:0] acl_y,
    input  logic [15:0] acl_z,
    output logic [2:0]  filt_ce,
    output logic [15:0] filt_gyro,
    output logic [15:0] filt_acl,
    output logic        filt_rst,
    input  logic [2:0]  filt_done,
    input  logic [15:0] filt_out_x,
    input  logic [15:0] filt_out_y,
    input  logic [15:0] filt_out_z,
    input  logic [2:0]  filt_motion,
    output logic [15:0] angle_x,
    output logic [15:0] angle_y,
    output logic [15:0] angle_z,
    output logic [2:0]  motion,
    output logic        motion_any,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        error,
    output logic [15:0] sample_cnt
);
    // The watchdog never fires before a nominal filter could have answered.
    localparam int WD_LIM = TIMEOUT > FILT_LAT + 2 ? TIMEOUT : FILT_LAT + 3;
    localparam int WW = $clog2(WD_LIM + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WD_LIM);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, ERR} state_t;
    state_t state, state_n;
    logic [1:0]    axis, axis_n;
    logic [2:0]    got, got_n, cap, ce_n, mo_n;
    logic [WW-1:0] wd, wd_n;
    logic [15:0]   gy_l, gz_l, ay_l, az_l;
    logic [15:0]   fg_n, fa_n, ax_n, ay_n, az_n, cnt_n;
    logic          frst_n, err_n, rdy_n, ov_n;

    always_comb begin
        state_n = state;
        axis_n  = axis;
        wd_n    = wd;
        cap     = (state == ISSUE || state == WAIT) ? filt_done & ~got : 3'b000;
        got_n   = got | cap;
        ce_n    = 3'b000;
        fg_n    = '0;
        fa_n    = '0;
        ax_n    = cap[0] ? filt_out_x : angle_x;
        ay_n    = cap[1] ? filt_out_y : angle_y;
        az_n    = cap[2] ? filt_out_z : angle_z;
        mo_n    = (motion & ~cap) | (filt_motion & cap);
        cnt_n   = sample_cnt;
        err_n   = error;
        frst_n  = 1'b0;
        case (state)
            IDLE: if (sample_valid && sample_ready) begin
                state_n = ISSUE;
                axis_n  = 2'd0;
                got_n   = 3'b000;
                ce_n    = 3'b001;
                fg_n    = gyro_x;
                fa_n    = acl_x;
            end
            ISSUE: if (axis == 2'd2) begin
                state_n = WAIT;
                wd_n    = '0;
            end else begin
                axis_n = axis + 2'd1;
                ce_n   = axis == 2'd0 ? 3'b010 : 3'b100;
                fg_n   = axis == 2'd0 ? gy_l : gz_l;
                fa_n   = axis == 2'd0 ? ay_l : az_l;
            end
            WAIT: if (&got_n) begin
                state_n = OUT;
            end else begin
                wd_n = wd + 1'b1;
                if (wd_n == WD_MAX) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    frst_n  = 1'b1;
                end
            end
            OUT: if (out_ready) begin
                state_n = IDLE;
                cnt_n   = sample_cnt + 16'd1;
            end
            default: state_n = IDLE;
        endcase
        if (clear) begin
            state_n = IDLE;
            frst_n  = 1'b1;
            err_n   = 1'b0;
            cnt_n   = '0;
            got_n   = 3'b000;
            ax_n    = '0;
            ay_n    = '0;
            az_n    = '0;
            mo_n    = 3'b000;
            ce_n    = 3'b000;
            fg_n    = '0;
            fa_n    = '0;
        end
        // Like power-up, a filter reset cycle is never also an accept cycle.
        rdy_n = state_n == IDLE && !frst_n;
        ov_n  = state_n == OUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            axis         <= '0;
            got          <= '0;
            wd           <= '0;
            gy_l         <= '0;
            gz_l         <= '0;
            ay_l         <= '0;
            az_l         <= '0;
            sample_ready <= 1'b0;
            filt_ce      <= '0;
            filt_gyro    <= '0;
            filt_acl     <= '0;
            filt_rst     <= 1'b1;
            angle_x      <= '0;
            angle_y      <= '0;
            angle_z      <= '0;
            motion       <= '0;
            motion_any   <= 1'b0;
            out_valid    <= 1'b0;
            error        <= 1'b0;
            sample_cnt   <= '0;
        end else begin
            state        <= state_n;
            axis         <= axis_n;
            got          <= got_n;
            wd           <= wd_n;
            sample_ready <= rdy_n;
            filt_ce      <= ce_n;
            filt_gyro    <= fg_n;
            filt_acl     <= fa_n;
            filt_rst     <= frst_n;
            angle_x      <= ax_n;
            angle_y      <= ay_n;
            angle_z      <= az_n;
            motion       <= mo_n;
            motion_any   <= |mo_n;
            out_valid    <= ov_n;
            error        <= err_n;
            sample_cnt   <= cnt_n;
            // X goes straight onto the bus; Y and Z wait here for their issue slot.
            if (state == IDLE && state_n == ISSUE) begin
                gy_l <= gyro_y;
                gz_l <= gyro_z;
                ay_l <= acl_y;
                az_l <= acl_z;
            end
        end
    end
endmodule

// File: tb/tb_fusion_sched.sv
// tb_fusion_sched: randomized samples through a latency-programmable filter model,
// scored against per-sample expected angles, motion flags, timing and counter.
module tb_fusion_sched;
    localparam int FILT_LAT = 5;
    localparam int TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clear = 1'b0, sample_valid = 1'b0, out_ready = 1'b0;
    logic        sample_ready, filt_rst, motion_any, out_valid, error;
    logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0, acl_x = '0, acl_y = '0, acl_z = '0;
    logic [15:0] filt_out_x = '0, filt_out_y = '0, filt_out_z = '0;
    logic [2:0]  filt_done = '0, filt_motion = '0;
    logic [2:0]  filt_ce, motion;
    logic [15:0] filt_gyro, filt_acl, angle_x, angle_y, angle_z, sample_cnt;

    int          cyc = 0, n_chk = 0, n_pass = 0;
    int          lat[3] = '{FILT_LAT, FILT_LAT, FILT_LAT};
    bit          drop[3] = '{1'b0, 1'b0, 1'b0};
    bit          dup_x = 1'b0;
    int          due[3] = '{-100, -100, -100};
    int          dupc = -100;
    logic [15:0] val[3];
    logic        mo[3];
    logic [15:0] exp_cnt = '0;

    fusion_sched #(.FILT_LAT(FILT_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .acl_x(acl_x), .acl_y(acl_y), .acl_z(acl_z),
        .filt_ce(filt_ce), .filt_gyro(filt_gyro), .filt_acl(filt_acl), .filt_rst(filt_rst),
        .filt_done(filt_done), .filt_out_x(filt_out_x), .filt_out_y(filt_out_y),
        .filt_out_z(filt_out_z), .filt_motion(filt_motion),
        .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
        .motion(motion), .motion_any(motion_any), .out_valid(out_valid),
        .out_ready(out_ready), .error(error), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ff(input logic [15:0] g, input logic [15:0] a);
        return 16'(g + a * 3) ^ 16'h5a5a;
    endfunction

    function automatic logic mf(input logic [15:0] g);
        return $signed(g) > 16'sd500 || $signed(g) < -16'sd500;
    endfunction

    function automatic logic [2:0] mot(input logic [2:0][15:0] g);
        return {mf(g[2]), mf(g[1]), mf(g[0])};
    endfunction

    // Filter model: answers FILT_LAT cycles after its ce, optional drop / duplicate X done.
    always @(negedge clk) begin
        if (filt_rst) begin
            due  = '{-100, -100, -100};
            dupc = -100;
        end
        for (int i = 0; i < 3; i++)
            if (filt_ce[i]) begin
                due[i] = cyc + lat[i];
                val[i] = ff(filt_gyro, filt_acl);
                mo[i]  = mf(filt_gyro);
            end
        if (filt_ce[0]) dupc = cyc + lat[0] + 2;
        for (int i = 0; i < 3; i++) begin
            filt_done[i]   = (!drop[i] && cyc == due[i]) || (i == 0 && dup_x && cyc == dupc);
            filt_motion[i] = cyc == due[i] ? mo[i] : 1'($urandom);
        end
        filt_out_x = cyc == due[0] ? val[0] : 16'($urandom);
        filt_out_y = cyc == due[1] ? val[1] : 16'($urandom);
        filt_out_z = cyc == due[2] ? val[2] : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic rnd(output logic [2:0][15:0] g, output logic [2:0][15:0] a);
        for (int i = 0; i < 3; i++) begin
            g[i] = $urandom_range(0, 1) ? 16'($urandom_range(0, 1500)) : -16'($urandom_range(0, 1500));
            a[i] = 16'($urandom);
        end
    endtask

    task automatic send(input logic [2:0][15:0] g, input logic [2:0][15:0] a, output int c0);
        for (int k = 0; k < 40 && !sample_ready; k++) @(negedge clk);
        chk("ready", sample_ready, 1);
        {gyro_z, gyro_y, gyro_x} = g;
        {acl_z, acl_y, acl_x} = a;
        sample_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
        {gyro_z, gyro_y, gyro_x} = {16'($urandom), 16'($urandom), 16'($urandom)};
        {acl_z, acl_y, acl_x} = {16'($urandom), 16'($urandom), 16'($urandom)};
        chk("accepted", sample_ready, 0);
    endtask

    task automatic wait_ov(output int t);
        for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
        chk("ov_seen", out_valid, 1);
        t = cyc;
    endtask

    task automatic chk_res(input logic [2:0][15:0] g, input logic [2:0][15:0] a);
        chk("angle_x", angle_x, ff(g[0], a[0]));
        chk("angle_y", angle_y, ff(g[1], a[1]));
        chk("angle_z", angle_z, ff(g[2], a[2]));
        chk("motion", motion, mot(g));
        chk("motion_any", motion_any, |mot(g));
    endtask

    task automatic finish(input logic [2:0][15:0] g, input logic [2:0][15:0] a, input int c0, input int hold);
        int t;
        wait_ov(t);
        chk("latency", t - c0, 9);
        chk_res(g, a);
        repeat (hold) begin
            @(negedge clk);
            chk("hold", {out_valid, sample_ready, angle_x, angle_y, angle_z, motion},
                {1'b1, 1'b0, ff(g[0], a[0]), ff(g[1], a[1]), ff(g[2], a[2]), mot(g)});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk("sample_cnt", sample_cnt, exp_cnt);
        chk("ov_drop", out_valid, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0][15:0] g, a, g2, a2;
        int c0, c1;
        int t;
        bit ovs;
        repeat (3) @(negedge clk);
        chk("rst_filt_rst", filt_rst, 1);
        chk("rst_ready", sample_ready, 0);
        chk("rst_outs", {filt_ce, out_valid, error, motion, sample_cnt, angle_x}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_filt_rst", filt_rst, 0);
        chk("rel_ready", sample_ready, 1);

        // Directed sample, out_ready held high: stagger, latency and throughput.
        g = {16'd0, 16'hFC18, 16'd1000};
        a = '0;
        out_ready = 1'b1;
        send(g, a, c0);
        chk("ce_x", {filt_ce, filt_gyro, filt_acl}, {3'b001, g[0], a[0]});
        @(negedge clk);
        chk("ce_y", {filt_ce, filt_gyro, filt_acl}, {3'b010, g[1], a[1]});
        @(negedge clk);
        chk("ce_z", {filt_ce, filt_gyro, filt_acl}, {3'b100, g[2], a[2]});
        @(negedge clk);
        chk("ce_off", filt_ce, 0);
        wait_ov(t);
        chk("first_latency", t - c0, 9);
        chk_res(g, a);
        chk("motion_011", motion, 3'b011);
        @(negedge clk);
        exp_cnt++;
        chk("cnt_first", sample_cnt, exp_cnt);
        chk("ready_c10", sample_ready, 1);
        rnd(g2, a2);
        send(g2, a2, c1);
        chk("throughput", c1 - c0, 10);
        out_ready = 1'b0;
        finish(g2, a2, c1, 0);

        // Backpressure: 20 held cycles, then acceptance.
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 20);

        // Random samples with random backpressure.
        for (int n = 0; n < 15; n++) begin
            rnd(g, a);
            send(g, a, c0);
            finish(g, a, c0, $urandom_range(0, 3));
        end

        // Z never answers: watchdog recovery.
        drop[2] = 1'b1;
        rnd(g, a);
        send(g, a, c0);
        ovs = 1'b0;
        for (int k = 0; k < 40 && !filt_rst; k++) begin
            ovs |= out_valid;
            @(negedge clk);
        end
        chk("err_cycle", cyc - c0, 19);
        chk("err_flag", error, 1);
        chk("err_cnt", sample_cnt, exp_cnt);
        @(negedge clk);
        chk("err_rst_pulse", {filt_rst, out_valid, ovs}, 0);
        drop[2] = 1'b0;
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 1);
        chk("err_sticky", error, 1);

        // X and Y done together, X repeated later with junk data.
        lat = '{FILT_LAT, FILT_LAT - 1, FILT_LAT};
        dup_x = 1'b1;
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 2);
        lat = '{FILT_LAT, FILT_LAT, FILT_LAT};
        dup_x = 1'b0;

        // Clear during WAIT.
        rnd(g, a);
        send(g, a, c0);
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_cnt = '0;
        chk("clr_filt_rst", filt_rst, 1);
        chk("clr_zero", {error, out_valid, motion, motion_any, sample_cnt, angle_x, filt_ce}, 0);
        @(negedge clk);
        chk("clr_rst_off", {filt_rst, sample_ready}, 2'b01);
        repeat (8) @(negedge clk);
        chk("clr_no_ov", out_valid, 0);

        // Clear together with out_ready in OUT: no count.
        rnd(g, a);
        send(g, a, c0);
        wait_ov(t);
        clear = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b0;
        chk("clr_out", {filt_rst, out_valid, sample_cnt}, {1'b1, 1'b0, 16'd0});
        @(negedge clk);

        // Counter wrap from a preloaded 0xFFFF.
        force dut.sample_cnt = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.sample_cnt;
        exp_cnt = 16'hFFFF;
        chk("preload", sample_cnt, 16'hFFFF);
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 0);
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 0);

        // Async reset mid-ISSUE.
        rnd(g, a);
        send(g, a, c0);
        rst_n = 1'b0;
        #1;
        chk("arst_filt_rst", filt_rst, 1);
        chk("arst_zero", {sample_ready, filt_ce, filt_gyro, out_valid, error, sample_cnt, angle_x, motion}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        chk("arst_recover", {filt_rst, sample_ready}, 2'b01);
        rnd(g, a);
        send(g, a, c0);
        finish(g, a, c0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
